// File: rtl/game_pkg.sv
// Shared constants for the memory game graphics: screen size, tile placement
// and colours, and the painter state encoding.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 8;
  localparam int CNT_W    = $clog2(40);
  localparam int COL_W    = 3;

  // Tile index order: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
  localparam logic [COORD_W-1:0] OX [0:3] = '{8'd40, 8'd100, 8'd40, 8'd100};
  localparam logic [COORD_W-1:0] OY [0:3] = '{8'd20, 8'd20, 8'd70, 8'd70};
  localparam logic [COL_W-1:0]   LIT [0:3] = '{3'b100, 3'b010, 3'b001, 3'b110};
  localparam logic [COL_W-1:0]   UNLIT     = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAINT,
    ST_HOLD,
    ST_RESTORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tile_pixel_scanner.sv
// Row-major cx/cy raster counter over one tile; `last` marks the final pixel.
module tile_pixel_scanner
  import game_pkg::*;
#(
  parameter int TILE_W = 20,
  parameter int TILE_H = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cx,
  output logic [CNT_W-1:0] cy,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(TILE_W - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(TILE_H - 1);

  logic [CNT_W-1:0] cx_q;
  logic [CNT_W-1:0] cy_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (en) begin
      if (cx_q == LAST_X) begin
        cx_q <= '0;
        cy_q <= (cy_q == LAST_Y) ? '0 : cy_q + CNT_W'(1);
      end else begin
        cx_q <= cx_q + CNT_W'(1);
      end
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == LAST_X) && (cy_q == LAST_Y);

endmodule

// File: rtl/tile_painter.sv
// Rasters one game tile to the VGA adapter write port, optionally flashing it
// (paint lit, hold, repaint unlit) behind a single start/done handshake.
module tile_painter
  import game_pkg::*;
#(
  parameter int TILE_W      = 20,
  parameter int TILE_H      = 20,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         tile,
  input  logic               flash,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COL_W-1:0]   colour,
  output logic               plot
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_CYCLES - 1);

  state_e             state_q;
  logic [1:0]         tile_q;
  logic               flash_q;
  logic [COL_W-1:0]   paint_col_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               fin_q;
  logic               busy_q;
  logic               done_q;
  logic               plot_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COL_W-1:0]   colour_q;

  logic [CNT_W-1:0]   cx;
  logic [CNT_W-1:0]   cy;
  logic               scan_last;
  logic               scan_clear;
  logic               scan_en;
  logic               drawing;

  assign drawing    = (state_q == ST_PAINT) || (state_q == ST_RESTORE);
  assign scan_en    = drawing && !fin_q;
  assign scan_clear = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_HOLD) && (hold_q == HOLD_END));

  tile_pixel_scanner #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_scanner (
    .clock (clock),
    .reset (reset),
    .clear (scan_clear),
    .en    (scan_en),
    .cx    (cx),
    .cy    (cy),
    .last  (scan_last)
  );

  // fin_q marks the spare cycle after the last pixel, so done is high while
  // the FSM sits in DONE and a start in that cycle is naturally ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tile_q      <= '0;
      flash_q     <= 1'b0;
      paint_col_q <= '0;
      hold_q      <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
    end else begin
      done_q <= 1'b0;
      plot_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            tile_q      <= tile;
            flash_q     <= flash;
            paint_col_q <= LIT[tile];
            fin_q       <= 1'b0;
            state_q     <= ST_PAINT;
          end
        end
        ST_PAINT, ST_RESTORE: begin
          if (fin_q) begin
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            busy_q   <= 1'b1;
            plot_q   <= 1'b1;
            x_q      <= OX[tile_q] + COORD_W'(cx);
            y_q      <= OY[tile_q] + COORD_W'(cy);
            colour_q <= paint_col_q;
            if (scan_last) begin
              if ((state_q == ST_PAINT) && flash_q) begin
                hold_q  <= '0;
                state_q <= ST_HOLD;
              end else begin
                fin_q <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          busy_q <= 1'b1;
          if (hold_q == HOLD_END) begin
            paint_col_q <= UNLIT;
            state_q     <= ST_RESTORE;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_tile_painter.sv
// Directed bench for tile_painter with a 4x3 tile and an 8-cycle flash hold.
module tb_tile_painter;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int HC = 8;
  localparam int NPIX = TW * TH;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] tile;
  logic       flash;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  tile_painter #(
    .TILE_W      (TW),
    .TILE_H      (TH),
    .HOLD_CYCLES (HC)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .tile   (tile),
    .flash  (flash),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Present a start for one edge, then scramble tile/flash to prove latching.
  task automatic start_op(input logic [1:0] t, input logic f);
    start = 1'b1;
    tile  = t;
    flash = f;
    tick();
    start = 1'b0;
    tile  = ~t;
    flash = ~f;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; tile = 2'd0; flash = 1'b0;
    tick();
    tick();
    checks++;
    if ({plot, busy, done, x, y, colour} !== 22'd0)
      $display("FAIL reset_outputs plot=%b busy=%b done=%b x=%0d y=%0d col=%b want all 0",
               plot, busy, done, x, y, colour);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({plot, busy, done} !== 3'b000)
        $display("FAIL idle_quiet cyc=%0d plot=%b busy=%b done=%b want 000", i, plot, busy, done);
      else passes++;
    end
    $display("test_reset: done");
  endtask

  task automatic test_nonflash;
    start_op(2'd1, 1'b0);
    checks++;
    if ({plot, busy} !== 2'b00)
      $display("FAIL nf_accept plot=%b busy=%b want 00", plot, busy);
    else passes++;
    for (int i = 0; i < NPIX; i++) begin
      tick();
      checks++;
      if ({plot, busy, done, x, y, colour} !== {3'b110, 8'(100 + i % TW), 8'(20 + i / TW), 3'b010})
        $display("FAIL nf_pixel i=%0d got p%b b%b d%b (%0d,%0d) %b want p1 b1 d0 (%0d,%0d) 010",
                 i, plot, busy, done, x, y, colour, 100 + i % TW, 20 + i / TW);
      else passes++;
    end
    tick();
    checks++;
    if ({plot, busy, done} !== 3'b001)
      $display("FAIL nf_done plot=%b busy=%b done=%b want 001", plot, busy, done);
    else passes++;
    tick();
    checks++;
    if ({plot, busy, done} !== 3'b000)
      $display("FAIL nf_after plot=%b busy=%b done=%b want 000", plot, busy, done);
    else passes++;
    $display("test_nonflash: tile1 done");
  endtask

  task automatic test_flash;
    start_op(2'd3, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      tick();
      checks++;
      if ({plot, busy, done, x, y, colour} !== {3'b110, 8'(100 + i % TW), 8'(70 + i / TW), 3'b110})
        $display("FAIL fl_lit i=%0d got p%b b%b d%b (%0d,%0d) %b want p1 b1 d0 (%0d,%0d) 110",
                 i, plot, busy, done, x, y, colour, 100 + i % TW, 70 + i / TW);
      else passes++;
    end
    for (int i = 0; i < HC; i++) begin
      tick();
      checks++;
      if ({plot, busy, done} !== 3'b010)
        $display("FAIL fl_hold cyc=%0d plot=%b busy=%b done=%b want 010", i, plot, busy, done);
      else passes++;
    end
    for (int i = 0; i < NPIX; i++) begin
      tick();
      checks++;
      if ({plot, busy, done, x, y, colour} !== {3'b110, 8'(100 + i % TW), 8'(70 + i / TW), 3'b111})
        $display("FAIL fl_unlit i=%0d got p%b b%b d%b (%0d,%0d) %b want p1 b1 d0 (%0d,%0d) 111",
                 i, plot, busy, done, x, y, colour, 100 + i % TW, 70 + i / TW);
      else passes++;
    end
    tick();
    checks++;
    if ({plot, busy, done} !== 3'b001)
      $display("FAIL fl_done plot=%b busy=%b done=%b want 001", plot, busy, done);
    else passes++;
    tick();
    $display("test_flash: tile3 done");
  endtask

  task automatic test_ignore_start;
    int dones;
    start_op(2'd2, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 4) begin start = 1'b1; tile = 2'd0; flash = 1'b1; end
      if (i == 5) start = 1'b0;
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, 8'(40 + i % TW), 8'(70 + i / TW), 3'b001})
        $display("FAIL ign_pixel i=%0d got p%b (%0d,%0d) %b want p1 (%0d,%0d) 001",
                 i, plot, x, y, colour, 40 + i % TW, 70 + i / TW);
      else passes++;
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
      checks++;
      if (i > 0 && plot !== 1'b0)
        $display("FAIL ign_extra cyc=%0d plot=%b want 0", i, plot);
      else passes++;
    end
    checks++;
    if (dones != 1) $display("FAIL ign_done_count got %0d want 1", dones);
    else passes++;
    $display("test_ignore_start: tile2 done");
  endtask

  task automatic test_reset_hold;
    int plots;
    start_op(2'd0, 1'b1);
    for (int i = 0; i < NPIX + 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({plot, busy, done} !== 3'b000)
      $display("FAIL rh_abort plot=%b busy=%b done=%b want 000", plot, busy, done);
    else passes++;
    plots = 0;
    for (int i = 0; i < 2 * NPIX + HC; i++) begin
      tick();
      if (plot || done) plots++;
    end
    checks++;
    if (plots != 0) $display("FAIL rh_no_restore plot/done cycles got %0d want 0", plots);
    else passes++;
    start_op(2'd0, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, 8'(40 + i % TW), 8'(20 + i / TW), 3'b100})
        $display("FAIL rh_repaint i=%0d got p%b (%0d,%0d) %b want p1 (%0d,%0d) 100",
                 i, plot, x, y, colour, 40 + i % TW, 20 + i / TW);
      else passes++;
    end
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL rh_done got %b want 1", done);
    else passes++;
    tick();
    $display("test_reset_hold: done");
  endtask

  task automatic test_done_cycle;
    start_op(2'd1, 1'b0);
    for (int i = 0; i < NPIX; i++) tick();
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL dc_done got %b want 1", done);
    else passes++;
    start = 1'b1; tile = 2'd2; flash = 1'b0;
    tick();
    checks++;
    if ({plot, busy, done} !== 3'b000)
      $display("FAIL dc_ignored plot=%b busy=%b done=%b want 000", plot, busy, done);
    else passes++;
    tick();
    start = 1'b0; tile = 2'd3;
    checks++;
    if (plot !== 1'b0) $display("FAIL dc_accept_edge plot=%b want 0", plot);
    else passes++;
    for (int i = 0; i < NPIX; i++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, 8'(40 + i % TW), 8'(70 + i / TW), 3'b001})
        $display("FAIL dc_pixel i=%0d got p%b (%0d,%0d) %b want p1 (%0d,%0d) 001",
                 i, plot, x, y, colour, 40 + i % TW, 70 + i / TW);
      else passes++;
    end
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL dc_done2 got %b want 1", done);
    else passes++;
    tick();
    $display("test_done_cycle: done");
  endtask

  initial begin
    test_reset();
    test_nonflash();
    test_flash();
    test_ignore_start();
    test_reset_hold();
    test_done_cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
